// File: rtl/button_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// button_conditioner_pkg
//   Shared definitions for the pushbutton conditioning slice.
//   - db_state_e : per-channel debounce FSM states (fixed 2-bit encodings)
//   - SYNC_DEPTH : number of synchronizer flops per raw input
// -----------------------------------------------------------------------------
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    RELEASED   = 2'b00,
    PRESS_PEND = 2'b01,
    PRESSED    = 2'b10,
    REL_PEND   = 2'b11
  } db_state_e;

  localparam int unsigned SYNC_DEPTH = 2;

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
//   One pushbutton channel: 2-FF synchronizer on the inverted raw input,
//   four-state debounce FSM with stable-cycle counter, registered outputs.
//
//   Parameters:
//     DEBOUNCE_COUNT  consecutive stable cycles needed to accept a change (>=2)
//   Ports:
//     clk        in   system clock
//     reset      in   asynchronous active-high reset
//     btn_in_n   in   raw button, active low, asynchronous
//     req_out    out  debounced level, active high
//     press_out  out  one-cycle pulse per accepted press
//
//   Macro BUTTON_COND_PULSE_EN: when defined the press pulse register is
//   built; otherwise press_out is tied low.
// -----------------------------------------------------------------------------
module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_COUNT = 120000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in_n,
  output logic req_out,
  output logic press_out
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_COUNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_COUNT - 1);

  logic [SYNC_DEPTH-1:0] sync_q, sync_d;
  db_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  req_q, req_d;
  logic                  sync;

  assign sync = sync_q[SYNC_DEPTH-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_DEPTH-2:0], ~btn_in_n};
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RELEASED: begin
        if (sync) begin
          state_d = PRESS_PEND;
          cnt_d   = '0;
        end
      end
      PRESS_PEND: begin
        if (!sync)                state_d = RELEASED;
        else if (cnt_q == CNT_LAST) state_d = PRESSED;
        else                      cnt_d   = cnt_q + 1'b1;
      end
      PRESSED: begin
        if (!sync) begin
          state_d = REL_PEND;
          cnt_d   = '0;
        end
      end
      REL_PEND: begin
        if (sync)                 state_d = PRESSED;
        else if (cnt_q == CNT_LAST) state_d = RELEASED;
        else                      cnt_d   = cnt_q + 1'b1;
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
    // Outputs decode the current state, so they trail the state register by
    // one edge; this places the rising edge at DEBOUNCE_COUNT+3 after sampling.
    req_d = (state_q == PRESSED) || (state_q == REL_PEND);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      state_q <= RELEASED;
      cnt_q   <= '0;
      req_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  assign req_out = req_q;

`ifdef BUTTON_COND_PULSE_EN
  logic press_q, press_d;

  // PRESSED while req is still low only happens on the first cycle after
  // PRESS_PEND->PRESSED; REL_PEND->PRESSED keeps req high and yields no pulse.
  always_comb begin
    press_d = (state_q == PRESSED) && !req_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) press_q <= 1'b0;
    else       press_q <= press_d;
  end

  assign press_out = press_q;
`else
  assign press_out = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//   Synchronizes and debounces two raw active-low pushbuttons into clean
//   active-high request levels plus one-cycle press pulses. The two channels
//   are fully independent.
//
//   Parameters:
//     CLOCK_FREQ      system clock in Hz
//     DEBOUNCE_COUNT  stable cycles to accept a change (default 10 ms)
//   Ports:
//     clk, reset               clock, asynchronous active-high reset
//     btn1_in_n, btn2_in_n     raw buttons, active low
//     req1_out, req2_out       debounced levels, active high
//     press1_out, press2_out   press pulses
//
//   Macro BUTTON_COND_PULSE_EN enables the press pulse outputs; when
//   undefined press1_out/press2_out are constant 0.
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int unsigned CLOCK_FREQ     = 12000000,
  parameter int unsigned DEBOUNCE_COUNT = CLOCK_FREQ / 100
) (
  input  logic clk,
  input  logic reset,
  input  logic btn1_in_n,
  input  logic btn2_in_n,
  output logic req1_out,
  output logic req2_out,
  output logic press1_out,
  output logic press2_out
);

  debounce_channel #(.DEBOUNCE_COUNT(DEBOUNCE_COUNT)) u_ch1 (
    .clk       (clk),
    .reset     (reset),
    .btn_in_n  (btn1_in_n),
    .req_out   (req1_out),
    .press_out (press1_out)
  );

  debounce_channel #(.DEBOUNCE_COUNT(DEBOUNCE_COUNT)) u_ch2 (
    .clk       (clk),
    .reset     (reset),
    .btn_in_n  (btn2_in_n),
    .req_out   (req2_out),
    .press_out (press2_out)
  );

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

`ifdef BUTTON_COND_PULSE_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic btn1_in_n, btn2_in_n;
  logic req1_out, req2_out, press1_out, press2_out;

  int unsigned checks = 0;
  int unsigned errors = 0;

  button_conditioner #(.CLOCK_FREQ(400), .DEBOUNCE_COUNT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn1_in_n  (btn1_in_n),
    .btn2_in_n  (btn2_in_n),
    .req1_out   (req1_out),
    .req2_out   (req2_out),
    .press1_out (press1_out),
    .press2_out (press2_out)
  );

  always #5 clk = ~clk;

  // Expected vector ordering: {req1, press1, req2, press2}
  function automatic logic [3:0] ex(input bit r1, input bit p1, input bit r2, input bit p2);
    return {r1, p1 & PE, r2, p2 & PE};
  endfunction

  task automatic chk(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {req1_out, press1_out, req2_out, press2_out};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Sample one time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    btn1_in_n = 1'b1;
    btn2_in_n = 1'b1;
    #1;
    chk("reset_state", ex(0, 0, 0, 0));
    cyc(); cyc();
    reset = 1'b0;

    // 1: reset mid-count with btn1 held low, then held through reset release.
    btn1_in_n = 1'b0;
    for (int e = 0; e < 5; e++) begin
      cyc();
      chk($sformatf("s1_count e%0d", e), ex(0, 0, 0, 0));
    end
    #2 reset = 1'b1;
    #1 chk("s1_reset_async", ex(0, 0, 0, 0));
    cyc(); cyc();
    reset = 1'b0;
    for (int e = 0; e < 12; e++) begin
      cyc();
      chk($sformatf("s1_after_reset e%0d", e), ex(e >= 7, e == 7, 0, 0));
    end
    btn1_in_n = 1'b1;
    for (int e = 0; e < 10; e++) cyc();
    chk("s1_idle", ex(0, 0, 0, 0));

    // 2: clean press held 20 cycles, then clean release.
    btn1_in_n = 1'b0;
    for (int e = 0; e < 20; e++) begin
      cyc();
      chk($sformatf("s2_press e%0d", e), ex(e >= 7, e == 7, 0, 0));
    end
    btn1_in_n = 1'b1;
    for (int e = 0; e < 12; e++) begin
      cyc();
      chk($sformatf("s2_release e%0d", e), ex(e < 7, 0, 0, 0));
    end

    // 3: btn2 bounces every 2 cycles for 16 cycles, then settles low.
    for (int i = 0; i < 16; i++) begin
      btn2_in_n = ((i / 2) % 2) != 0;
      cyc();
      chk($sformatf("s3_bounce i%0d", i), ex(0, 0, 0, 0));
    end
    btn2_in_n = 1'b0;
    for (int e = 0; e < 12; e++) begin
      cyc();
      chk($sformatf("s3_settle e%0d", e), ex(0, 0, e >= 7, e == 7));
    end
    btn2_in_n = 1'b1;
    for (int e = 0; e < 10; e++) cyc();
    chk("s3_idle", ex(0, 0, 0, 0));

    // 4: btn1 glitch of 3 cycles is rejected.
    btn1_in_n = 1'b0;
    for (int e = 0; e < 15; e++) begin
      if (e == 3) btn1_in_n = 1'b1;
      cyc();
      chk($sformatf("s4_glitch e%0d", e), ex(0, 0, 0, 0));
    end

    // 5: simultaneous presses, then asynchronous reset while both pressed.
    btn1_in_n = 1'b0;
    btn2_in_n = 1'b0;
    for (int e = 0; e < 12; e++) begin
      cyc();
      chk($sformatf("s5_both e%0d", e), ex(e >= 7, e == 7, e >= 7, e == 7));
    end
    #2 reset = 1'b1;
    #1 chk("s5_reset_async", ex(0, 0, 0, 0));
    btn1_in_n = 1'b1;
    btn2_in_n = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    for (int e = 0; e < 10; e++) begin
      cyc();
      chk($sformatf("s5_post_reset e%0d", e), ex(0, 0, 0, 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
